// File: rtl/maxnet_pkg.sv
// Shared defaults and width helpers for the Maxnet winner-take-all datapath.
// Imported by the neuron lanes and the datapath top.

package maxnet_pkg;

   localparam int unsigned NDef       = 4;
   localparam int unsigned WDef       = 16;
   localparam int unsigned FDef       = 8;
   localparam int unsigned EpsDef     = 26;
   localparam int unsigned MaxIterDef = 255;

   localparam int unsigned IterW = 8;

   // Width used for the inhibition subtraction before ReLU/saturation.
   function automatic int unsigned sat_w(input int unsigned n, input int unsigned w);
      return w + $clog2(n) + 1;
   endfunction

   localparam int unsigned SatWDef = sat_w(NDef, WDef);

endpackage

// File: rtl/maxnet_neuron.sv
// One Maxnet lane: activation t, scaled self-term p and next activation nxt.
// Two free-running stages; t only changes on load_t.

module maxnet_neuron
   import maxnet_pkg::*;
#(
   parameter int unsigned W    = WDef,
   parameter int unsigned F    = FDef,
   parameter int unsigned EPS  = EpsDef,
   parameter int unsigned SumW = WDef + $clog2(NDef),
   parameter int unsigned SatW = SatWDef
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_t_i,
   input  logic            select_t_i,
   input  logic [W-1:0]    x_i,
   input  logic [SumW-1:0] p_sum_i,
   output logic [W-1:0]    t_o,
   output logic [W-1:0]    p_o,
   output logic            nz_o
);

   localparam int unsigned ProdW = W + F + 1;
   localparam logic signed [ProdW-1:0] EpsS   = ProdW'(EPS);
   localparam logic signed [SatW-1:0]  MaxPos = SatW'((64'd1 << (W - 1)) - 64'd1);

   logic signed [W-1:0]     t_q, t_d;
   logic signed [W-1:0]     p_q, p_d;
   logic signed [W-1:0]     nxt_q, nxt_d;
   logic signed [ProdW-1:0] prod;
   logic signed [SatW-1:0]  diff;

   always_comb begin
      prod = ProdW'(t_q) * EpsS;
      // Arithmetic shift floors toward -inf.
      p_d  = W'(prod >>> F);

      diff = SatW'(t_q) - (SatW'($signed(p_sum_i)) - SatW'(p_q));
      if (diff < 0) begin
         nxt_d = '0;
      end else if (diff > MaxPos) begin
         nxt_d = W'(MaxPos);
      end else begin
         nxt_d = W'(diff);
      end

      t_d = t_q;
      if (load_t_i) begin
         if (select_t_i) begin
            t_d = x_i[W-1] ? '0 : $signed(x_i);
         end else begin
            t_d = nxt_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         t_q   <= '0;
         p_q   <= '0;
         nxt_q <= '0;
      end else begin
         t_q   <= t_d;
         p_q   <= p_d;
         nxt_q <= nxt_d;
      end
   end

   assign t_o  = t_q;
   assign p_o  = p_q;
   assign nz_o = (nxt_q != '0);

endmodule

// File: rtl/maxnet_datapath.sv
// Maxnet datapath top: N neuron lanes, inhibition sum, convergence detect,
// winner priority encoder, iteration counter and input-hold registers.

module maxnet_datapath
   import maxnet_pkg::*;
#(
   parameter int unsigned N        = NDef,
   parameter int unsigned W        = WDef,
   parameter int unsigned F        = FDef,
   parameter int unsigned EPS      = EpsDef,
   parameter int unsigned MAX_ITER = MaxIterDef
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_x,
   input  logic                 load_t,
   input  logic                 select_t,
   input  logic [N*W-1:0]       x_in,
   output logic [N*W-1:0]       t_out,
   output logic                 done,
   output logic [$clog2(N)-1:0] winner,
   output logic                 winner_valid,
   output logic [W-1:0]         winner_x,
   output logic [IterW-1:0]     iter_count,
   output logic                 timeout
);

   localparam int unsigned IdxW = $clog2(N);
   localparam int unsigned SumW = W + $clog2(N);
   localparam int unsigned SatW = sat_w(N, W);
   localparam int unsigned CntW = $clog2(N + 1);
   localparam logic [IterW-1:0] IterLast = IterW'(MAX_ITER - 1);
   localparam logic [IterW-1:0] IterSat  = '1;

   logic [N*W-1:0]      x_reg_q, x_reg_d;
   logic [IterW-1:0]    iter_q, iter_d;
   logic                timeout_q, timeout_d;
   logic [N-1:0][W-1:0] t_lane;
   logic [N-1:0][W-1:0] p_lane;
   logic [N-1:0]        nz;
   logic [SumW-1:0]     p_sum;
   logic [CntW-1:0]     nz_cnt;
   logic                at_limit;

   for (genvar g = 0; g < N; g++) begin : g_neuron
      maxnet_neuron #(
         .W    (W),
         .F    (F),
         .EPS  (EPS),
         .SumW (SumW),
         .SatW (SatW)
      ) u_neuron (
         .clk        (clk),
         .rst        (rst),
         .load_t_i   (load_t),
         .select_t_i (select_t),
         .x_i        (x_in[g*W +: W]),
         .p_sum_i    (p_sum),
         .t_o        (t_lane[g]),
         .p_o        (p_lane[g]),
         .nz_o       (nz[g])
      );
   end

   always_comb begin
      p_sum  = '0;
      nz_cnt = '0;
      for (int i = 0; i < N; i++) begin
         p_sum  = p_sum + SumW'($signed(p_lane[i]));
         nz_cnt = nz_cnt + CntW'(nz[i]);
      end
      at_limit = (iter_q == IterLast);
      done     = (nz_cnt <= CntW'(1)) || at_limit;
   end

   // Descending scan so the lowest nonzero index wins.
   always_comb begin
      winner       = '0;
      winner_valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (t_lane[i] != '0) begin
            winner       = IdxW'(i);
            winner_valid = 1'b1;
         end
      end
      winner_x = x_reg_q[int'(winner)*W +: W];
   end

   always_comb begin
      x_reg_d   = load_x ? x_in : x_reg_q;
      iter_d    = iter_q;
      timeout_d = timeout_q;
      if (load_t) begin
         if (select_t) begin
            iter_d    = '0;
            timeout_d = 1'b0;
         end else begin
            if (iter_q != IterSat) begin
               iter_d = iter_q + IterW'(1);
            end
            timeout_d = at_limit;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_reg_q   <= '0;
         iter_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         x_reg_q   <= x_reg_d;
         iter_q    <= iter_d;
         timeout_q <= timeout_d;
      end
   end

   assign t_out      = t_lane;
   assign iter_count = iter_q;
   assign timeout    = timeout_q;

endmodule

// File: doc/maxnet_datapath.md
# maxnet_datapath

Datapath for the Maxnet winner-take-all core, driven by the Maxnet controller's `load_x` / `load_t` / `select_t` strobes. It returns `done` to that controller.
- Holds N neuron activations and computes one lateral-inhibition iteration across the controller's Mul and Add cycles.
- Commits the iteration on the Update cycle.
- Reports convergence, the winning index and an iteration count.

## Interface
- `N`, 4: number of neurons; `$clog2(N)` gives the winner-index width.
- `W`, 16: activation width, signed two's complement, Q(W-F).F.
- `F`, 8: fractional bits.
- `EPS`, 26: inhibition weight, unsigned Q0.F (26 ≈ 0.1016); must satisfy EPS < 2^F/N.
- `MAX_ITER`, 255: iteration limit before forced `done`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `load_x`  in  1  capture `x_in` into the input-hold registers.
- `load_t`  in  1  write the activation registers.
- `select_t`  in  1  activation source: 1 = clamped `x_in`, 0 = computed next value.
- `x_in`  in  N*W  packed inputs; lane i at bits [i*W +: W].
- `t_out`  out  N*W  current activation registers.
- `done`  out  1  convergence or timeout of the pending update (combinational).
- `winner`  out  $clog2(N)  index of the lowest-index nonzero activation.
- `winner_valid`  out  1  at least one activation is nonzero.
- `winner_x`  out  W  held input value of `winner`.
- `iter_count`  out  8  committed iterations since the last initial load.
- `timeout`  out  1  the last commit was forced by `MAX_ITER`.

## Operation
- **Clamp.** Negative `x_in` lanes are clamped to 0 whenever they are loaded into `t`.
- **Hold registers.** `x_reg` captures raw `x_in` on `load_x`; it is used only for `winner_x`.
- **Free-running pipeline.** Both stages update every cycle with no enable:
  - Stage 1: `p[j] <= (t[j] * EPS) >>> F`, truncating toward −∞, width W.
  - Stage 2: `nxt[i] <= ReLU(t[i] − (P − p[i]))`, where P = Σp[j].
    - Computed in W+$clog2(N)+1 bits.
    - Negative results become 0; results above 2^(W−1)−1 saturate to that value.
- **Activation write on `load_t`:**
  - `select_t` = 1: `t[i] <=` clamp(`x_in[i]`); `iter_count <= 0`; `timeout <= 0`.
  - `select_t` = 0: `t[i] <= nxt[i]`; `iter_count` increments, saturating at 255.
- **`done`.** Asserted when (number of nonzero `nxt` ≤ 1) OR (`iter_count` == MAX_ITER−1).
  - `timeout <=` the second term alone, registered on a `load_t` with `select_t` = 0.
- **Winner outputs.** `winner`, `winner_valid` and `winner_x` are combinational from `t` and `x_reg`.
  - With no nonzero lane: `winner` = 0, `winner_valid` = 0.
- **Tie handling.** Tied maxima never separate; only `MAX_ITER` terminates them.
- **Write precedence.** `load_t` has precedence over nothing else; `load_x` and `load_t` in the same cycle are independent writes.

## Timing
- **Reset.** Clears `x_reg`, `t`, `p`, `nxt`, `iter_count` and `timeout` to 0.
  - After reset: `t_out` = 0, `winner` = 0, `winner_valid` = 0, `winner_x` = 0, `iter_count` = 0, `timeout` = 0, `done` = 1 (all-zero `nxt`).
- **Latency.** `t` must be stable for 2 full cycles before a `select_t` = 0 `load_t` commits a correct `nxt`.
  - The controller guarantees this: Init loads `t` → Mul fills `p` → Add fills `nxt` → Update commits `nxt`.
- **`done` sampling.** `done` is valid during Update, i.e. the cycle in which `load_t` is high with `select_t` = 0.
  - Between Update and the following Add, `done` reflects stale `nxt` and must be ignored.
- **Repeated Init.** `load_t` with `select_t` = 1 held for several cycles (start held) reloads every cycle; `iter_count` stays 0.
- **Reset mid-iteration.** All state is cleared on that edge; no partial commit.

## Structure
- Package `maxnet_pkg`: default N, W, F, EPS and MAX_ITER constants, plus the saturate/ReLU width constant.
- Sub-module `maxnet_neuron`, instanced N times:
  - Holds `t[i]`, `p[i]` and `nxt[i]`.
  - Takes P, `load_t`, `select_t` and `x_in[i]`.
  - Outputs `t[i]`, `p[i]` and the `nxt[i]` ≠ 0 flag.
- Top level: sums P, counts nonzero lanes, and contains the priority encoder, iteration counter and `x_reg`.

## Test plan
- **Basic iteration.** `x_in` = {256,128,64,32}, Init then Mul/Add/Update.
  - Expected `p` = {26,13,6,3}, P = 48.
  - After Update `t_out` = {234,93,22,0}, `done` = 0, `iter_count` = 1.
  - Continue until `done` = 1; expect `winner` = 0, `winner_x` = 256, `timeout` = 0.
- **Single nonzero.** `x_in` = {0,0,300,0} → `done` = 1 at the first Update; `winner` = 2, `iter_count` = 1, `t_out[2]` = 300.
- **Negative clamp.** `x_in` = {−50,10,0,0} → `t_out` = {0,10,0,0} after Init; `done` = 1 at the first Update; `winner` = 1, `winner_x` = 10.
- **Tie.** `x_in` = {100,100,0,0}, `MAX_ITER` = 8 → `done` stays 0 until the 8th Update, then `done` = 1 and `timeout` = 1.
  - Lanes 0 and 1 remain equal; `winner` = 0.
- **Reset and restart.** Assert `rst` during the Add cycle of the first iteration → all outputs return to reset values.
  - A new Init with {0,0,0,0} gives `done` = 1 and `winner_valid` = 0.
